vga_sync_monitor: RTL
=====================

// Module: vga_sync_monitor
// PURPOSE
//  Receive-side counterpart of the VGA display timing path. Samples HS/VS/BLANK/RGB
//  as driven to the DAC and recovers the pixel coordinate of each active pixel.
//  Measures line and frame geometry and declares lock once timing is stable.
//  Used in-system as a loopback checker and as a capture front end for VGA-format streams.
// PARAMETERS
//  H_TOTAL      800  expected clocks per line (HS falling edge to HS falling edge)
//  V_TOTAL      525  expected lines per frame (VS falling edge to VS falling edge)
//  H_ACT        640  expected active pixels per line (BLANK high run length)
//  V_ACT        480  expected active lines per frame
//  LOCK_FRAMES  2    consecutive good frames required to declare lock (1..15)
// PORTS
//  i_clk          in   1   pixel clock (25 MHz)
//  i_rst_n        in   1   asynchronous active-low reset
//  i_hs           in   1   horizontal sync, active low
//  i_vs           in   1   vertical sync, active low
//  i_blank        in   1   1 = active video, 0 = blanking
//  i_R/i_G/i_B    in   8   pixel colour
//  o_R/o_G/o_B    out  8   pixel colour aligned with o_x/o_y
//  o_x            out  10  active pixel column 0..H_ACT-1
//  o_y            out  10  active line 0..V_ACT-1
//  o_pix_valid    out  1   o_x/o_y/o_RGB valid this cycle
//  o_frame_start  out  1   1-cycle pulse on each detected VS falling edge
//  o_locked       out  1   timing locked
//  o_err          out  1   1-cycle pulse on a timing violation while locked
//  o_err_cnt      out  8   violation count, saturates at 255
// BEHAVIOUR
//  Reset (i_rst_n=0, async): all outputs 0, FSM=SEARCH, all counters 0, sampled hs/vs=1.
//  Stage 1 registers all inputs. Edges are detected between stage-1 value and its
//   previous value: hs_fall, vs_fall, blk_rise, blk_fall.
//  Every output is registered in stage 2. Latency is fixed at 2 clocks from input to o_*.
//  h_cnt (11b): 0 on hs_fall, else +1, saturating at 2047. On hs_fall, line_len = h_cnt+1.
//   Skip the line_len check on the first hs_fall after reset or after a SEARCH entry.
//  v_cnt (10b): counts hs_fall. On vs_fall, frame_len = v_cnt, then v_cnt = hs_fall?1:0.
//   A coincident hs_fall starts the new frame's first line.
//  x_cnt: 0 on blk_rise, +1 each cycle that blank is high. On blk_fall, act_len = x_cnt.
//   o_x = x_cnt value for the current pixel (first active pixel has x=0).
//  y_cnt: 0 on vs_fall, +1 on each blk_fall. o_y = y_cnt during the active run.
//  Line bad: line_len != H_TOTAL or act_len != H_ACT.
//  Frame bad: any bad line in the frame, frame_len != V_TOTAL, or y_cnt at vs_fall != V_ACT.
//  frame_ok is set at vs_fall and cleared by any bad line.
//  FSM:
//   SEARCH -> CHECK on first vs_fall (partial frame not judged), good_cnt=0.
//   CHECK: at vs_fall, good frame -> good_cnt+1; bad frame -> good_cnt=0.
//    Go to LOCKED when good_cnt reaches LOCK_FRAMES.
//   LOCKED: a bad line (at hs_fall) or bad frame (at vs_fall) does all of:
//    o_err pulse, o_err_cnt+1 (saturating), CHECK with good_cnt=0.
//  Watchdog: h_cnt == 2047 (sync lost) -> SEARCH from any state.
//   If the state was LOCKED, also pulse o_err and increment o_err_cnt.
//  Simultaneous bad line and bad frame in one cycle: a single o_err and a single increment.
//  o_locked = (state==LOCKED), registered.
//  o_pix_valid = o_locked & stage-1 blank, aligned with o_x/o_y/o_RGB.
//  When o_pix_valid=0, o_x/o_y/o_RGB hold their last values.
//  o_frame_start pulses on every vs_fall regardless of lock.
//  Mid-frame reset: on release, restart from SEARCH. No stale measurement is used.
// TESTING
//  1 Nominal 800x525 stream, 640x480 active, from reset.
//    -> o_locked rises 2 clocks after the 3rd VS fall.
//    -> First valid pixel: x=0, y=0. Last valid pixel: x=639, y=479. o_err_cnt=0.
//  2 Locked; one line stretched to 801 clocks.
//    -> o_err pulses once, o_locked drops, o_err_cnt=1.
//    -> Relock after 2 further good frames.
//  3 Locked; HS held high for 2100 clocks.
//    -> Watchdog: SEARCH, o_err=1, o_locked=0.
//    -> Resume stream: relock after 3 VS falls.
//  4 Frame of 524 lines while in CHECK.
//    -> good_cnt resets, no o_err, o_locked stays 0.
//  5 Ramp RGB equal to x[7:0]: check o_R == o_x[7:0] on every valid pixel (2-clock alignment).
//  6 Assert i_rst_n=0 mid-line while locked.
//    -> All outputs 0 immediately.
//    -> After release, lock reacquired normally. Force 300 errors -> o_err_cnt saturates at 255.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from HS/VS/BLANK,
// measures line/frame geometry and declares lock after consecutive good frames.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_blank,
  input  logic [7:0] i_R,
  input  logic [7:0] i_G,
  input  logic [7:0] i_B,
  output logic [7:0] o_R,
  output logic [7:0] o_G,
  output logic [7:0] o_B,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_pix_valid,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_err,
  output logic [7:0] o_err_cnt
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_e;

  localparam logic [10:0] H_MAX   = 11'h7FF;
  localparam logic [9:0]  V_MAX   = 10'h3FF;
  localparam logic [11:0] H_TOT_W = 12'(H_TOTAL);
  localparam logic [10:0] H_ACT_W = 11'(H_ACT);
  localparam logic [9:0]  V_TOT_W = 10'(V_TOTAL);
  localparam logic [9:0]  V_ACT_W = 10'(V_ACT);
  localparam logic [3:0]  LOCK_W  = 4'(LOCK_FRAMES);

  logic        hs_q, vs_q, blank_q, hsPrev_q, vsPrev_q, blankPrev_q;
  logic [23:0] rgb_q;
  logic [10:0] hCnt_q, hCnt_d, xCnt_q, xCnt_d, actLen_q, actLen_d;
  logic [9:0]  vCnt_q, vCnt_d, yCnt_q, yCnt_d;
  logic        lineSeen_q, lineSeen_d, actSeen_q, actSeen_d, frameOk_q, frameOk_d;
  state_e      state_q, state_d;
  logic [3:0]  goodCnt_q, goodCnt_d, goodNext;
  logic [9:0]  xOut_q, yOut_q;
  logic [23:0] rgbOut_q;
  logic        pixValid_q, pixValid_d, frameStart_q, locked_q, err_q, errHit;
  logic [7:0]  errCnt_q, errCnt_d;

  logic        hsFall, vsFall, blkRise, blkFall, watchdog, lineBad, frameBad;
  logic [11:0] lineLen;
  logic [10:0] pixX, actNow;

  assign hsFall  = hsPrev_q & ~hs_q;
  assign vsFall  = vsPrev_q & ~vs_q;
  assign blkRise = ~blankPrev_q & blank_q;
  assign blkFall = blankPrev_q & ~blank_q;
  assign lineLen = {1'b0, hCnt_q} + 12'd1;
  assign pixX    = blkRise ? 11'd0 : xCnt_q;
  assign actNow  = blkFall ? xCnt_q : actLen_q;
  // A saturated h_cnt only means sync loss when no HS edge is arriving right now.
  assign watchdog = (hCnt_q == H_MAX) && !hsFall;

  // Lines without an active run are judged on length only; missing runs show up in y_cnt.
  assign lineBad  = hsFall && lineSeen_q &&
                    ((lineLen != H_TOT_W) || ((actSeen_q || blkFall) && (actNow != H_ACT_W)));
  assign frameBad = !frameOk_q || lineBad || (vCnt_q != V_TOT_W) || (yCnt_q != V_ACT_W);

  always_comb begin
    hCnt_d     = hsFall ? 11'd0 : ((hCnt_q == H_MAX) ? H_MAX : hCnt_q + 11'd1);
    vCnt_d     = vCnt_q;
    if (vsFall)
      vCnt_d = hsFall ? 10'd1 : 10'd0;
    else if (hsFall && vCnt_q != V_MAX)
      vCnt_d = vCnt_q + 10'd1;
    xCnt_d     = xCnt_q;
    if (blank_q)
      xCnt_d = (pixX == H_MAX) ? H_MAX : pixX + 11'd1;
    actLen_d   = blkFall ? xCnt_q : actLen_q;
    yCnt_d     = yCnt_q;
    if (vsFall)
      yCnt_d = 10'd0;
    else if (blkFall && yCnt_q != V_MAX)
      yCnt_d = yCnt_q + 10'd1;
    lineSeen_d = watchdog ? 1'b0 : (hsFall ? 1'b1 : lineSeen_q);
    actSeen_d  = (hsFall || watchdog) ? 1'b0 : (blkFall ? 1'b1 : actSeen_q);
    frameOk_d  = vsFall ? 1'b1 : (lineBad ? 1'b0 : frameOk_q);
  end

  always_comb begin
    state_d   = state_q;
    goodCnt_d = goodCnt_q;
    goodNext  = goodCnt_q + 4'd1;
    errHit    = 1'b0;
    if (watchdog) begin
      state_d   = SEARCH;
      goodCnt_d = 4'd0;
      errHit    = (state_q == LOCKED);
    end else begin
      case (state_q)
        SEARCH: if (vsFall) begin
          state_d   = CHECK;
          goodCnt_d = 4'd0;
        end
        CHECK: if (vsFall) begin
          if (frameBad) begin
            goodCnt_d = 4'd0;
          end else begin
            goodCnt_d = goodNext;
            if (goodNext >= LOCK_W) state_d = LOCKED;
          end
        end
        LOCKED: if (lineBad || (vsFall && frameBad)) begin
          errHit    = 1'b1;
          state_d   = CHECK;
          goodCnt_d = 4'd0;
        end
        default: state_d = SEARCH;
      endcase
    end
    pixValid_d = (state_d == LOCKED) && blank_q;
    errCnt_d   = (errHit && errCnt_q != 8'hFF) ? errCnt_q + 8'd1 : errCnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_q <= 1'b1;  vs_q <= 1'b1;  blank_q <= 1'b0;  rgb_q <= '0;
      hsPrev_q <= 1'b1;  vsPrev_q <= 1'b1;  blankPrev_q <= 1'b0;
      hCnt_q <= '0;  vCnt_q <= '0;  xCnt_q <= '0;  yCnt_q <= '0;  actLen_q <= '0;
      lineSeen_q <= 1'b0;  actSeen_q <= 1'b0;  frameOk_q <= 1'b0;
      state_q <= SEARCH;  goodCnt_q <= '0;
      xOut_q <= '0;  yOut_q <= '0;  rgbOut_q <= '0;
      pixValid_q <= 1'b0;  frameStart_q <= 1'b0;  locked_q <= 1'b0;
      err_q <= 1'b0;  errCnt_q <= '0;
    end else begin
      hs_q <= i_hs;  vs_q <= i_vs;  blank_q <= i_blank;  rgb_q <= {i_R, i_G, i_B};
      hsPrev_q <= hs_q;  vsPrev_q <= vs_q;  blankPrev_q <= blank_q;
      hCnt_q <= hCnt_d;  vCnt_q <= vCnt_d;  xCnt_q <= xCnt_d;  yCnt_q <= yCnt_d;
      actLen_q <= actLen_d;
      lineSeen_q <= lineSeen_d;  actSeen_q <= actSeen_d;  frameOk_q <= frameOk_d;
      state_q <= state_d;  goodCnt_q <= goodCnt_d;
      if (pixValid_d) begin
        xOut_q   <= pixX[9:0];
        yOut_q   <= yCnt_q;
        rgbOut_q <= rgb_q;
      end
      pixValid_q   <= pixValid_d;
      frameStart_q <= vsFall;
      locked_q     <= (state_d == LOCKED);
      err_q        <= errHit;
      errCnt_q     <= errCnt_d;
    end
  end

  assign o_R           = rgbOut_q[23:16];
  assign o_G           = rgbOut_q[15:8];
  assign o_B           = rgbOut_q[7:0];
  assign o_x           = xOut_q;
  assign o_y           = yOut_q;
  assign o_pix_valid   = pixValid_q;
  assign o_frame_start = frameStart_q;
  assign o_locked      = locked_q;
  assign o_err         = err_q;
  assign o_err_cnt     = errCnt_q;

endmodule
